iter_encryptor: RTL and testbench
=================================

ITER_ENCRYPTOR -- requirements
Module: iter_encryptor

Interface
REQ-001 Parameter NUM_ROUNDS, default 5, number of key-driven rounds; legal range 1..16.
REQ-002 Parameter ROWS, default 4, number of 32-bit rows in the state; legal range 1..8; state width W = 32*ROWS.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  source offers a block.
REQ-006 in_ready  output  1  engine can accept a block.
REQ-007 mode  input  1  0 = encrypt, 1 = decrypt; sampled with the block.
REQ-008 in_data  input  W  plaintext or ciphertext; byte i = bits [8i+7:8i]; row j = bytes 4j..4j+3.
REQ-009 key  input  2*NUM_ROUNDS  round key bits, sampled with the block.
REQ-010 out_valid  output  1  result available.
REQ-011 out_ready  input  1  sink accepts the result.
REQ-012 out_data  output  W  result block.

Function
REQ-013 FSM states IDLE, RUN, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-014 IDLE: on in_valid=1, register in_data, key, and mode, clear the round counter, go to RUN.
REQ-015 RUN: apply exactly one round per clock; after the NUM_ROUNDS-th round go to DONE.
REQ-016 Latency: block accepted at edge T, so out_valid rises at edge T+NUM_ROUNDS.
REQ-017 DONE: hold out_data and out_valid stable until out_ready=1, then go to IDLE at that edge.
REQ-018 No overlap: a new block is never accepted in the same cycle as a result is accepted; back-to-back throughput is one block per NUM_ROUNDS+2 cycles.
REQ-019 Round r (0-based) uses key bits kh = key[2*(NUM_ROUNDS-1-r)+1] and kl = key[2*(NUM_ROUNDS-1-r)], so round 0 uses the MSB pair.
REQ-020 Encrypt rounds run r = 0..NUM_ROUNDS-1.
  - Step 1: swap the nibbles of every byte, then XOR every byte with RC = (r+1) mod 256.
  - Step 2: if kh=1, rotate every row left by 8 bits ({B3,B2,B1,B0} becomes {B2,B1,B0,B3}).
  - Step 3: if kl=1, XOR every byte with 8'hA5.
REQ-021 Decrypt rounds run r = NUM_ROUNDS-1 down to 0 and apply the exact inverse steps in reverse order.
  - Step 1: if kl=1, XOR every byte with 8'hA5.
  - Step 2: if kh=1, rotate every row right by 8 bits.
  - Step 3: XOR every byte with RC, then swap the nibbles of every byte.
REQ-022 For any key and data, decrypt(encrypt(x)) = x bit-exactly.
REQ-023 Changes on in_data, key, or mode after acceptance shall not affect the block in flight.
REQ-024 out_data is the working state register and is observable in every state; it is meaningful only while out_valid=1.

Reset
REQ-025 Reset takes effect asynchronously.
  - State goes to IDLE.
  - Round counter = 0.
  - out_data = 0; out_valid = 0; in_ready = 1.
REQ-026 Reset asserted during RUN or DONE discards the block with no output; after deassertion the engine behaves as in IDLE on the next edge.

Configuration
REQ-027 Macro CRYPT_DECRYPT_EN.
  - When defined: the mode input and the decrypt datapath of REQ-021 are present.
  - When undefined: the decrypt datapath is not synthesised, mode is ignored, and every block is encrypted.
  - All other timing is unchanged in both builds.

Verification
REQ-028 NUM_ROUNDS=1, ROWS=4, mode=0, key=2'b00, in_data all 0x00 -> out_data all bytes 0x01, out_valid at T+1.
REQ-029 Same setup with key=2'b01 -> all bytes 0xA4.
REQ-030 NUM_ROUNDS=1, key=2'b10, row0 = 32'h04030201, other rows 0 -> row0 = 32'h31211141, other rows 32'h01010101.
REQ-031 Defaults, CRYPT_DECRYPT_EN defined, 1000 random (data, key): encrypt, then decrypt the result with the same key -> original data returned; each out_valid at T+5.
REQ-032 Hold out_ready=0 for 3 cycles in DONE -> out_data and out_valid stable and in_ready=0 throughout; accept on the 4th cycle -> IDLE on the next edge.
REQ-033 Assert rst in the 2nd RUN cycle -> out_valid=0, in_ready=1, out_data=0 immediately; the next block is processed correctly.

Source files
------------

// File: rtl/iter_encryptor.sv
// Iterative block cipher engine: one key-driven round per clock over a ROWS x 32-bit state.
// Optional decrypt datapath and mode input enabled by CRYPT_DECRYPT_EN.
module iter_encryptor #(
  parameter int unsigned NUM_ROUNDS = 5,
  parameter int unsigned ROWS       = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    mode,
  input  logic [32*ROWS-1:0]      in_data,
  input  logic [2*NUM_ROUNDS-1:0] key,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [32*ROWS-1:0]      out_data
);

  localparam int unsigned W  = 32 * ROWS;
  localparam int unsigned NB = 4 * ROWS;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [4:0]              rnd_q;
  logic [2*NUM_ROUNDS-1:0] key_q;
  logic [W-1:0]            round_next;
  logic                    last_round;

  assign last_round = (rnd_q == 5'(NUM_ROUNDS - 1));

  // Encrypt: round index equals the counter; key pairs are consumed MSB pair first.
  logic [4:0]   enc_kidx;
  logic [1:0]   enc_kp;
  logic [7:0]   enc_rc;
  logic [W-1:0] enc_next;

  assign enc_kidx = 5'(NUM_ROUNDS - 1) - rnd_q;
  assign enc_kp   = 2'(key_q >> {enc_kidx, 1'b0});
  assign enc_rc   = {3'b000, rnd_q} + 8'd1;

  always_comb begin
    enc_next = out_data;
    for (int i = 0; i < NB; i++) begin
      enc_next[8*i +: 8] = {out_data[8*i +: 4], out_data[8*i+4 +: 4]} ^ enc_rc;
    end
    if (enc_kp[1]) begin
      for (int j = 0; j < ROWS; j++) begin
        enc_next[32*j +: 32] = {enc_next[32*j +: 24], enc_next[32*j+24 +: 8]};
      end
    end
    if (enc_kp[0]) begin
      enc_next = enc_next ^ {NB{8'hA5}};
    end
  end

`ifdef CRYPT_DECRYPT_EN
  // Decrypt walks rounds backwards, so the counter value is itself the key pair index.
  logic         mode_q;
  logic [1:0]   dec_kp;
  logic [7:0]   dec_rc;
  logic [W-1:0] dec_next;

  assign dec_kp = 2'(key_q >> {rnd_q, 1'b0});
  assign dec_rc = {3'b000, 5'(NUM_ROUNDS - 1) - rnd_q} + 8'd1;

  always_comb begin
    dec_next = out_data;
    if (dec_kp[0]) begin
      dec_next = dec_next ^ {NB{8'hA5}};
    end
    if (dec_kp[1]) begin
      for (int j = 0; j < ROWS; j++) begin
        dec_next[32*j +: 32] = {dec_next[32*j +: 8], dec_next[32*j+8 +: 24]};
      end
    end
    for (int i = 0; i < NB; i++) begin
      dec_next[8*i +: 8] = dec_next[8*i +: 8] ^ dec_rc;
      dec_next[8*i +: 8] = {dec_next[8*i +: 4], dec_next[8*i+4 +: 4]};
    end
  end

  assign round_next = mode_q ? dec_next : enc_next;
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign round_next  = enc_next;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      rnd_q     <= '0;
      key_q     <= '0;
      out_data  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
`ifdef CRYPT_DECRYPT_EN
      mode_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        StIdle: begin
          if (in_valid) begin
            out_data <= in_data;
            key_q    <= key;
`ifdef CRYPT_DECRYPT_EN
            mode_q   <= mode;
`endif
            rnd_q    <= '0;
            in_ready <= 1'b0;
            state_q  <= StRun;
          end
        end
        StRun: begin
          out_data <= round_next;
          rnd_q    <= rnd_q + 5'd1;
          if (last_round) begin
            out_valid <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_q   <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_iter_encryptor.sv
// Bench for iter_encryptor: byte-array reference model with a per-cycle compare process on a
// default-sized instance, plus directed single-round vectors on a NUM_ROUNDS=1 instance.
module tb_iter_encryptor;

  localparam int N = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b0;

  logic         in_valid = 1'b0, in_ready, mode = 1'b0, out_valid, out_ready = 1'b0;
  logic [127:0] in_data = '0, out_data;
  logic [9:0]   key = '0;

  logic         s_in_valid = 1'b0, s_in_ready, s_out_valid, s_out_ready = 1'b1;
  logic [127:0] s_in_data = '0, s_out_data;
  logic [1:0]   s_key = '0;

  iter_encryptor #(.NUM_ROUNDS(N), .ROWS(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .in_data(in_data), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data)
  );

  iter_encryptor #(.NUM_ROUNDS(1), .ROWS(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .mode(1'b0),
    .in_data(s_in_data), .key(s_key), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [127:0] exp_q[$];
  int           acc_q[$];
  bit           chk_en = 0;
  bit           seen = 0;
  bit           expect_idle = 0;
  int           stall_cfg = 0;
  int           stall_left = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: state as 16 bytes, rounds applied from the rule text.
  function automatic logic [127:0] enc_model(input logic [127:0] d, input logic [31:0] k,
                                             input int n);
    logic [7:0]   b[16];
    logic [7:0]   t;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = d[8*i +: 8];
    for (int rr = 0; rr < n; rr++) begin
      for (int i = 0; i < 16; i++) b[i] = {b[i][3:0], b[i][7:4]} ^ 8'(rr + 1);
      if (k[2*(n-1-rr)+1]) begin
        for (int j = 0; j < 4; j++) begin
          t = b[4*j+3];
          b[4*j+3] = b[4*j+2];
          b[4*j+2] = b[4*j+1];
          b[4*j+1] = b[4*j];
          b[4*j] = t;
        end
      end
      if (k[2*(n-1-rr)]) for (int i = 0; i < 16; i++) b[i] = b[i] ^ 8'hA5;
    end
    for (int i = 0; i < 16; i++) r[8*i +: 8] = b[i];
    return r;
  endfunction

  // Compare process and sink for the default instance.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && !rst) begin
        if (expect_idle) begin
          chk("idle_in_ready", 128'(in_ready), 128'd1);
          chk("idle_out_valid", 128'(out_valid), 128'd0);
          expect_idle = 0;
        end
        if (exp_q.size() == 0) begin
          chk("no_output_valid", 128'(out_valid), 128'd0);
        end else if (cyc < acc_q[0] + N) begin
          chk("busy_out_valid", 128'(out_valid), 128'd0);
          chk("busy_in_ready", 128'(in_ready), 128'd0);
        end else begin
          chk("latency_out_valid", 128'(out_valid), 128'd1);
          if (out_valid) begin
            chk("out_data", out_data, exp_q[0]);
            chk("done_in_ready", 128'(in_ready), 128'd0);
            if (!seen) begin
              seen = 1;
              stall_left = stall_cfg;
            end
            if (stall_left > 0) begin
              out_ready = 1'b0;
              stall_left--;
            end else begin
              out_ready = 1'b1;
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen = 0;
              expect_idle = 1;
            end
          end
        end
      end
    end
  end

  task automatic send(input logic [127:0] d, input logic [9:0] k, input logic m,
                      input logic [127:0] exp);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      chk("send_ready_timeout", 128'(in_ready), 128'd1);
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    key      = k;
    mode     = m;
    @(posedge clk);
    #1;
    exp_q.push_back(exp);
    acc_q.push_back(cyc);
    in_valid = 1'b0;
    in_data  = ~d;
    key      = ~k;
    mode     = ~m;
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    @(negedge clk);
  endtask

  task automatic run1(input string name, input logic [127:0] d, input logic [1:0] k,
                      input logic [127:0] exp);
    chk({name, "_model"}, enc_model(d, 32'(k), 1), exp);
    @(negedge clk);
    s_in_valid = 1'b1;
    s_in_data  = d;
    s_key      = k;
    @(posedge clk);
    #1;
    s_in_valid = 1'b0;
    s_in_data  = ~d;
    s_key      = ~k;
    @(negedge clk);
    chk({name, "_early_valid"}, 128'(s_out_valid), 128'd0);
    @(negedge clk);
    chk({name, "_valid"}, 128'(s_out_valid), 128'd1);
    chk({name, "_data"}, s_out_data, exp);
    @(negedge clk);
    chk({name, "_idle"}, 128'(s_in_ready), 128'd1);
  endtask

  logic [127:0] x, c, y;
  logic [9:0]   kk;

  initial begin
    #1 rst = 1'b1;
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_out_data", out_data, 128'd0);
    chk("rst1_in_ready", 128'(s_in_ready), 128'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1;

    run1("r028", 128'd0, 2'b00, {16{8'h01}});
    run1("r029", 128'd0, 2'b01, {16{8'hA4}});
    run1("r030", 128'h04030201, 2'b10,
         {32'h01010101, 32'h01010101, 32'h01010101, 32'h31211141});

    // Result held for three cycles, then accepted.
    x = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    stall_cfg = 3;
    send(x, 10'b10_01_11_00_10, 1'b0, enc_model(x, 32'(10'b10_01_11_00_10), N));
    drain();
    stall_cfg = 0;

    // Reset during the second RUN cycle.
    send(x, 10'h2B5, 1'b0, enc_model(x, 32'(10'h2B5), N));
    @(posedge clk);
    #2;
    chk_en = 0;
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'd0);
    chk("midrst_in_ready", 128'(in_ready), 128'd1);
    chk("midrst_out_data", out_data, 128'd0);
    exp_q.delete();
    acc_q.delete();
    seen = 0;
    expect_idle = 0;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1;
    y = 128'hDEADBEEF_01234567_89ABCDEF_FEDCBA98;
    send(y, 10'h155, 1'b0, enc_model(y, 32'(10'h155), N));
    drain();

`ifdef CRYPT_DECRYPT_EN
    for (int i = 0; i < 1000; i++) begin
      x  = {$urandom, $urandom, $urandom, $urandom};
      kk = 10'($urandom);
      c  = enc_model(x, 32'(kk), N);
      send(x, kk, 1'b0, c);
      send(c, kk, 1'b1, x);
      if (i == 3) stall_cfg = 2;
      if (i == 6) stall_cfg = 0;
    end
`else
    for (int i = 0; i < 100; i++) begin
      x  = {$urandom, $urandom, $urandom, $urandom};
      kk = 10'($urandom);
      send(x, kk, 1'($urandom), enc_model(x, 32'(kk), N));
    end
`endif
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
